// File: rtl/ci_pipe_harness.sv
`default_nettype none
// =============================================================================
// Module      : ci_pipe_harness
// Description : Custom-instruction wrapper for a fixed-latency pipelined core.
//               Done comes from a token pipe; CI_PERF_CNT_EN enables perf_count.
// Revision    : 1.0 - initial release
// =============================================================================
module ci_pipe_harness #(
    parameter int DATA_W     = 32,
    parameter int IN_STAGES  = 1,
    parameter int CORE_LAT   = 3,
    parameter int OUT_STAGES = 1,
    parameter int PERF_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [DATA_W-1:0] dataa,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic [DATA_W-1:0] core_dataa,
    output logic              core_clk_en,
    input  logic [DATA_W-1:0] core_result,
    output logic [PERF_W-1:0] perf_count
);

    localparam int c_total_lat = IN_STAGES + CORE_LAT + OUT_STAGES;

    generate
        if (IN_STAGES < 1) begin : g_bad_in_stages
            $error("ci_pipe_harness: IN_STAGES must be >= 1");
        end
        if (OUT_STAGES < 1) begin : g_bad_out_stages
            $error("ci_pipe_harness: OUT_STAGES must be >= 1");
        end
    endgenerate

    assign core_clk_en = clk_en;

    // Operand pipe shifts on every enabled edge regardless of start.
    logic [DATA_W-1:0] r_in_pipe [IN_STAGES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IN_STAGES; i++) begin
                r_in_pipe[i] <= '0;
            end
        end else if (clk_en) begin
            r_in_pipe[0] <= dataa;
            for (int i = 1; i < IN_STAGES; i++) begin
                r_in_pipe[i] <= r_in_pipe[i-1];
            end
        end
    end

    assign core_dataa = r_in_pipe[IN_STAGES-1];

    logic [DATA_W-1:0] w_res_aligned;

    generate
        if (OUT_STAGES > 1) begin : g_out_pipe
            logic [DATA_W-1:0] r_out_pipe [OUT_STAGES-1];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < OUT_STAGES - 1; i++) begin
                        r_out_pipe[i] <= '0;
                    end
                end else if (clk_en) begin
                    r_out_pipe[0] <= core_result;
                    for (int i = 1; i < OUT_STAGES - 1; i++) begin
                        r_out_pipe[i] <= r_out_pipe[i-1];
                    end
                end
            end

            assign w_res_aligned = r_out_pipe[OUT_STAGES-2];
        end else begin : g_out_direct
            assign w_res_aligned = core_result;
        end
    endgenerate

    // Token bit L-2 marks the cycle whose aligned core data becomes the result.
    logic [c_total_lat-1:0] r_tok;
    logic [DATA_W-1:0]      r_result;
    logic                   w_load;

    assign w_load = r_tok[c_total_lat-2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tok    <= '0;
            r_result <= '0;
        end else if (clk_en) begin
            r_tok <= {r_tok[c_total_lat-2:0], start};
            if (w_load) begin
                r_result <= w_res_aligned;
            end
        end
    end

    assign done   = r_tok[c_total_lat-1];
    assign result = r_result;

`ifdef CI_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf <= '0;
        end else if (clk_en && w_load) begin
            r_perf <= r_perf + PERF_W'(1);
        end
    end

    assign perf_count = r_perf;
`else
    assign perf_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ci_pipe_harness.sv
`default_nettype none
// =============================================================================
// Module      : tb_ci_pipe_harness
// Description : Directed self-checking bench for ci_pipe_harness (two configs).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_ci_pipe_harness;

`ifdef CI_PERF_CNT_EN
    localparam bit c_perf_on = 1'b1;
`else
    localparam bit c_perf_on = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;

    logic [31:0] result_a, core_dataa_a, core_result_a, perf_a;
    logic        done_a, core_clk_en_a;
    logic [31:0] result_b, core_dataa_b, core_result_b;
    logic [3:0]  perf_b;
    logic        done_b, core_clk_en_b;

    logic [31:0] r_s1, r_s2, r_s3;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done_b;
    logic [31:0] exp_res;
    logic [15:0] pat;

    ci_pipe_harness dut_a (
        .clock       (clock),
        .reset       (reset),
        .clk_en      (clk_en),
        .start       (start),
        .dataa       (dataa),
        .result      (result_a),
        .done        (done_a),
        .core_dataa  (core_dataa_a),
        .core_clk_en (core_clk_en_a),
        .core_result (core_result_a),
        .perf_count  (perf_a)
    );

    ci_pipe_harness #(
        .DATA_W     (32),
        .IN_STAGES  (2),
        .CORE_LAT   (0),
        .OUT_STAGES (3),
        .PERF_W     (4)
    ) dut_b (
        .clock       (clock),
        .reset       (reset),
        .clk_en      (clk_en),
        .start       (start),
        .dataa       (dataa),
        .result      (result_b),
        .done        (done_b),
        .core_dataa  (core_dataa_b),
        .core_clk_en (core_clk_en_b),
        .core_result (core_result_b),
        .perf_count  (perf_b)
    );

    // Stub core A: +1 with three enabled register stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else if (core_clk_en_a) begin
            r_s1 <= core_dataa_a + 32'd1;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end
    assign core_result_a = r_s3;

    // Stub core B: combinational +1.
    assign core_result_b = core_dataa_b + 32'd1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        tick();
        tick();
        check("rst_result", result_a, 32'h0);
        check("rst_done", {31'b0, done_a}, 32'h0);
        check("rst_perf", perf_a, 32'h0);
        check("rst_done_b", {31'b0, done_b}, 32'h0);
        reset = 1'b0;
        tick();

        // Single operation: done only in cycle 5.
        start = 1'b1;
        dataa = 32'h3F80_0000;
        tick();
        start = 1'b0;
        dataa = 32'hDEAD_BEEF;
        for (int k = 1; k <= 8; k++) begin
            check("single_done", {31'b0, done_a}, {31'b0, k == 5});
            check("single_res", result_a, (k >= 5) ? 32'h3F80_0001 : 32'h0);
            tick();
        end
        check("perf_after_single", perf_a, c_perf_on ? 32'd1 : 32'd0);

        // Four back-to-back operations.
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            dataa = 32'(i + 1);
            tick();
        end
        start = 1'b0;
        dataa = 32'h0;
        for (int k = 4; k <= 10; k++) begin
            check("b2b_done", {31'b0, done_a}, {31'b0, (k >= 5) && (k <= 8)});
            check("b2b_res", result_a, (k < 5) ? 32'h3F80_0001 : ((k <= 8) ? 32'(k - 3) : 32'd5));
            tick();
        end
        check("perf_after_b2b", perf_a, c_perf_on ? 32'd5 : 32'd0);

        // clk_en low in cycles 2..4, with an ignored start in cycle 3.
        start = 1'b1;
        dataa = 32'h10;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            clk_en = !((k >= 2) && (k <= 4));
            start  = (k == 3);
            dataa  = (k == 3) ? 32'h99 : 32'h0;
            check("gate_done", {31'b0, done_a}, {31'b0, k == 8});
            check("gate_res", result_a, (k >= 8) ? 32'h11 : 32'h5);
            tick();
        end
        clk_en = 1'b1;
        start  = 1'b0;

        // clk_en low while done is high: done stretches over cycles 5..7.
        start = 1'b1;
        dataa = 32'h20;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            clk_en = !((k == 5) || (k == 6));
            check("hold_done", {31'b0, done_a}, {31'b0, (k >= 5) && (k <= 7)});
            check("hold_res", result_a, (k >= 5) ? 32'h21 : 32'h11);
            tick();
        end
        clk_en = 1'b1;
        check("perf_after_gate", perf_a, c_perf_on ? 32'd7 : 32'd0);

        // Reset pulse in cycle 2 discards the in-flight operation.
        start = 1'b1;
        dataa = 32'h30;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        check("rstmid_res", result_a, 32'h0);
        check("rstmid_perf", perf_a, 32'h0);
        for (int k = 2; k <= 9; k++) begin
            check("rstmid_done", {31'b0, done_a}, 32'h0);
            check("rstmid_hold", result_a, 32'h0);
            tick();
        end
        start = 1'b1;
        dataa = 32'h40;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check("fresh_done", {31'b0, done_a}, {31'b0, k == 5});
            check("fresh_res", result_a, (k >= 5) ? 32'h41 : 32'h0);
            tick();
        end

        // Config B (2/0/3): starts at cycles 0,2,3,6 keep their gaps.
        pat     = 16'b0000_0000_0100_1101;
        exp_res = 32'h41;
        for (int k = 0; k <= 14; k++) begin
            start = pat[k];
            dataa = 32'h50 + 32'(k);
            if (k >= 5 && pat[k-5]) begin
                exp_res = 32'h50 + 32'(k - 5) + 32'd1;
            end
            check("gap_done_b", {31'b0, done_b}, {31'b0, (k >= 5) && pat[k-5]});
            check("gap_res_b", result_b, exp_res);
            tick();
        end
        start = 1'b0;

        // 17 operations: 4-bit counter wraps to 1.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        n_done_b = 0;
        for (int k = 0; k <= 22; k++) begin
            start = (k <= 16);
            dataa = 32'(k);
            if (done_b) n_done_b++;
            if (k == 16) begin
                check("perf_b_mid", {28'b0, perf_b}, c_perf_on ? 32'd12 : 32'd0);
            end
            tick();
        end
        start = 1'b0;
        check("done_b_count", 32'(n_done_b), 32'd17);
        check("perf_b_wrap", {28'b0, perf_b}, c_perf_on ? 32'd1 : 32'd0);
        check("perf_a_17", perf_a, c_perf_on ? 32'd17 : 32'd0);
        check("final_res_b", result_b, 32'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
